// File: rtl/obi_pkg.sv
// Shared types and constants for the two-primary OBI arbiter.
package obi_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_REQ  = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_e;

  localparam logic [31:0] OBI_ERR_RDATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/obi_resp_timer.sv
// Response-wait counter: saturating, cleared at the subordinate handshake,
// flags the last allowed cycle before a synthetic response is due.
module obi_resp_timer #(
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned CW = (TIMEOUT_CYC == 0) ? 1 : $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en && (cnt_q != CNT_MAX)) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  // A zero limit disables the timeout entirely
  assign expired = (TIMEOUT_CYC != 0) && (cnt_q == CNT_LAST);

endmodule

// File: rtl/obi_arb2_primary.sv
// Round-robin arbiter between two OBI primaries onto a single-outstanding
// subordinate, with a response timeout that returns a synthetic error word.
module obi_arb2_primary
  import obi_pkg::*;
#(
  parameter int unsigned AW          = 32,
  parameter int unsigned DW          = 32,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              p0_req_i,
  output logic              p0_gnt_o,
  input  logic [AW-1:0]     p0_addr_i,
  input  logic              p0_we_i,
  input  logic [DW/8-1:0]   p0_be_i,
  input  logic [DW-1:0]     p0_wdata_i,
  output logic              p0_rvalid_o,
  output logic [DW-1:0]     p0_rdata_o,
  input  logic              p1_req_i,
  output logic              p1_gnt_o,
  input  logic [AW-1:0]     p1_addr_i,
  input  logic              p1_we_i,
  input  logic [DW/8-1:0]   p1_be_i,
  input  logic [DW-1:0]     p1_wdata_i,
  output logic              p1_rvalid_o,
  output logic [DW-1:0]     p1_rdata_o,
  output logic              s_req_o,
  input  logic              s_gnt_i,
  output logic [AW-1:0]     s_addr_o,
  output logic              s_we_o,
  output logic [DW/8-1:0]   s_be_o,
  output logic [DW-1:0]     s_wdata_o,
  input  logic              s_rvalid_i,
  input  logic [DW-1:0]     s_rdata_i,
  output logic              timeout_o
);

  localparam int unsigned BW = DW / 8;

  arb_state_e    state_q, state_d;
  logic          sel_q, prio_q, sel_c;
  logic [AW-1:0] addr_q;
  logic          we_q;
  logic [BW-1:0] be_q;
  logic [DW-1:0] wdata_q;
  logic          any_req_c, hs_c, fwd_c, synth_c, expired_c, rsp_valid_c;
  logic [DW-1:0] rsp_data_c;

  assign any_req_c = p0_req_i | p1_req_i;
  assign sel_c     = (p0_req_i && p1_req_i) ? prio_q : p1_req_i;

  // Next-state and per-cycle event decode
  always_comb begin
    state_d = state_q;
    hs_c    = 1'b0;
    fwd_c   = 1'b0;
    synth_c = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (any_req_c) state_d = ARB_REQ;
      end
      ARB_REQ: begin
        if (s_gnt_i) begin
          hs_c    = 1'b1;
          state_d = ARB_RESP;
        end
      end
      ARB_RESP: begin
        if (s_rvalid_i) begin
          fwd_c   = 1'b1;
          state_d = ARB_IDLE;
        end else if (expired_c) begin
          synth_c = 1'b1;
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= ARB_IDLE;
    else       state_q <= state_d;
  end

  // Winner selection and request capture; fields stay frozen until the next arbitration
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sel_q   <= 1'b0;
      prio_q  <= 1'b0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
    end else begin
      if ((state_q == ARB_IDLE) && any_req_c) begin
        sel_q   <= sel_c;
        addr_q  <= sel_c ? p1_addr_i  : p0_addr_i;
        we_q    <= sel_c ? p1_we_i    : p0_we_i;
        be_q    <= sel_c ? p1_be_i    : p0_be_i;
        wdata_q <= sel_c ? p1_wdata_i : p0_wdata_i;
      end
      if (fwd_c || synth_c) prio_q <= ~sel_q;
    end
  end

  obi_resp_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timer (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clr    (hs_c),
    .en     ((state_q == ARB_RESP) && !s_rvalid_i),
    .expired(expired_c)
  );

  assign s_req_o   = (state_q == ARB_REQ);
  assign s_addr_o  = addr_q;
  assign s_we_o    = we_q;
  assign s_be_o    = be_q;
  assign s_wdata_o = wdata_q;

  assign p0_gnt_o  = hs_c & ~sel_q;
  assign p1_gnt_o  = hs_c & sel_q;

  // A real response on the expiry cycle takes precedence over the error word
  assign rsp_valid_c = fwd_c | synth_c;
  assign rsp_data_c  = fwd_c ? s_rdata_i : DW'(OBI_ERR_RDATA);

  assign p0_rvalid_o = rsp_valid_c & ~sel_q;
  assign p1_rvalid_o = rsp_valid_c & sel_q;
  assign p0_rdata_o  = p0_rvalid_o ? rsp_data_c : '0;
  assign p1_rdata_o  = p1_rvalid_o ? rsp_data_c : '0;
  assign timeout_o   = synth_c;

endmodule

// File: tb/tb_obi_arb2_primary.sv
// Scoreboard bench for obi_arb2_primary: randomized rounds against a
// transaction-level round-robin model and a scripted subordinate.
module tb_obi_arb2_primary;

  localparam int TMO = 8;
  localparam int M_NORM = 0, M_EXACT = 1, M_TMO = 2;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          gnt_lat;
    int          resp_lat;
    int          mode;
  } txn_t;

  typedef struct {
    int          port;
    logic [31:0] rdata;
    logic        tmo;
  } exp_t;

  logic        clk, rst;
  logic        p0_req, p0_gnt, p0_we, p0_rvalid;
  logic [31:0] p0_addr, p0_wdata, p0_rdata;
  logic [3:0]  p0_be;
  logic        p1_req, p1_gnt, p1_we, p1_rvalid;
  logic [31:0] p1_addr, p1_wdata, p1_rdata;
  logic [3:0]  p1_be;
  logic        s_req, s_gnt, s_we, s_rvalid, timeout;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic [3:0]  s_be;

  obi_arb2_primary #(.AW(32), .DW(32), .TIMEOUT_CYC(TMO)) dut (
    .clk_i(clk), .rst_i(rst),
    .p0_req_i(p0_req), .p0_gnt_o(p0_gnt), .p0_addr_i(p0_addr), .p0_we_i(p0_we),
    .p0_be_i(p0_be), .p0_wdata_i(p0_wdata), .p0_rvalid_o(p0_rvalid), .p0_rdata_o(p0_rdata),
    .p1_req_i(p1_req), .p1_gnt_o(p1_gnt), .p1_addr_i(p1_addr), .p1_we_i(p1_we),
    .p1_be_i(p1_be), .p1_wdata_i(p1_wdata), .p1_rvalid_o(p1_rvalid), .p1_rdata_o(p1_rdata),
    .s_req_o(s_req), .s_gnt_i(s_gnt), .s_addr_o(s_addr), .s_we_o(s_we), .s_be_o(s_be),
    .s_wdata_o(s_wdata), .s_rvalid_i(s_rvalid), .s_rdata_i(s_rdata), .timeout_o(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_chk = 0, n_pass = 0;
  int   prio = 0;
  int   cyc = 0, last_hs = -1;
  bit   busy = 0, sub_en = 1;
  int   gnt_q[$];
  exp_t exp_q[$];
  txn_t plan_q[$];
  int   mp;
  exp_t me;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] want);
    n_chk++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, want);
  endtask

  task automatic check_zero(input string name);
    chk({name, "_ctl"}, {p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, s_req, s_we, s_be, timeout}, 0);
    chk({name, "_data"}, {p0_rdata, p1_rdata, s_addr, s_wdata}, 0);
  endtask

  function automatic txn_t mk_txn(input logic [31:0] addr, input logic we, input logic [3:0] be,
                                  input logic [31:0] wdata, input logic [31:0] rdata,
                                  input int gl, input int rl, input int mode);
    txn_t t;
    t.addr = addr; t.we = we; t.be = be; t.wdata = wdata; t.rdata = rdata;
    t.gnt_lat = gl; t.resp_lat = rl; t.mode = mode;
    return t;
  endfunction

  function automatic txn_t rand_txn();
    int r;
    txn_t t;
    r = int'($urandom_range(0, 9));
    t.addr = $urandom & 32'hFFFF_FFFC;
    t.we = 1'($urandom);
    t.be = 4'($urandom);
    t.wdata = $urandom;
    t.rdata = $urandom;
    t.gnt_lat = ($urandom_range(0, 7) == 0) ? 10 : int'($urandom_range(0, 3));
    t.mode = (r == 0) ? M_TMO : (r == 1) ? M_EXACT : M_NORM;
    t.resp_lat = (t.mode == M_EXACT) ? TMO - 1 : int'($urandom_range(0, TMO - 2));
    return t;
  endfunction

  // Scoreboard monitor: pops an expectation whenever the DUT presents gnt or rvalid
  always @(negedge clk) begin
    if (!rst) begin
      cyc++;
      if (p0_gnt || p1_gnt) begin
        if (gnt_q.size() == 0) chk("unexpected_gnt", {p1_gnt, p0_gnt}, 0);
        else begin
          mp = gnt_q.pop_front();
          chk("gnt_port", {p1_gnt, p0_gnt}, (mp != 0) ? 2'b10 : 2'b01);
        end
      end
      if (s_req && s_gnt) begin
        if (last_hs >= 0) chk("hs_gap_ge3", 1'((cyc - last_hs) >= 3), 1);
        last_hs = cyc;
      end
      if (p0_rvalid || p1_rvalid) begin
        if (exp_q.size() == 0) chk("unexpected_rvalid", {p1_rvalid, p0_rvalid}, 0);
        else begin
          me = exp_q.pop_front();
          chk("rvalid_port", {p1_rvalid, p0_rvalid}, (me.port != 0) ? 2'b10 : 2'b01);
          chk("rdata", (me.port != 0) ? p1_rdata : p0_rdata, me.rdata);
          chk("timeout_flag", timeout, me.tmo);
        end
      end else begin
        chk("timeout_without_rvalid", timeout, 0);
      end
      if (!p0_rvalid) chk("p0_rdata_idle", p0_rdata, 0);
      if (!p1_rvalid) chk("p1_rdata_idle", p1_rdata, 0);
    end
  end

  task automatic check_fields(input txn_t t);
    chk("s_fields", {s_req, s_addr, s_we, s_be, s_wdata}, {1'b1, t.addr, t.we, t.be, t.wdata});
  endtask

  task automatic serve(input txn_t t);
    for (int i = 0; i < t.gnt_lat; i++) begin
      check_fields(t);
      @(posedge clk); #1;
    end
    check_fields(t);
    s_gnt = 1'b1;
    @(posedge clk); #1;
    s_gnt = 1'b0;
    if (t.mode == M_TMO) begin
      // Late response two cycles after the timeout must be dropped
      repeat (TMO + 1) begin @(posedge clk); #1; end
      s_rvalid = 1'b1;
      s_rdata  = 32'h57A1_E000;
    end else begin
      repeat (t.resp_lat) begin @(posedge clk); #1; end
      s_rvalid = 1'b1;
      s_rdata  = t.rdata;
    end
    @(posedge clk); #1;
    s_rvalid = 1'b0;
    s_rdata  = '0;
  endtask

  // Scripted subordinate: serves planned transactions in model grant order
  initial begin
    s_gnt = 1'b0; s_rvalid = 1'b0; s_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (sub_en) begin
        s_gnt = 1'b0; s_rvalid = 1'b0; s_rdata = '0;
        if (s_req && !rst) begin
          busy = 1;
          if (plan_q.size() == 0) chk("plan_underflow", 1, 0);
          else serve(plan_q.pop_front());
          busy = 0;
        end
      end
    end
  end

  task automatic run_round(input bit m0, input bit m1, input txn_t t0, input txn_t t1);
    int   order[$];
    txn_t t;
    exp_t e;
    bit   g0, g1, done;
    if (m0 && m1) begin
      order.push_back(prio);
      order.push_back(1 - prio);
    end else begin
      order.push_back(m1 ? 1 : 0);
    end
    foreach (order[i]) begin
      t = (order[i] != 0) ? t1 : t0;
      e.port  = order[i];
      e.tmo   = (t.mode == M_TMO);
      e.rdata = e.tmo ? 32'hDEAD_BEEF : t.rdata;
      gnt_q.push_back(order[i]);
      plan_q.push_back(t);
      exp_q.push_back(e);
      prio = 1 - order[i];
    end
    @(posedge clk); #1;
    if (m0) begin p0_req = 1; p0_addr = t0.addr; p0_we = t0.we; p0_be = t0.be; p0_wdata = t0.wdata; end
    if (m1) begin p1_req = 1; p1_addr = t1.addr; p1_we = t1.we; p1_be = t1.be; p1_wdata = t1.wdata; end
    done = 0;
    for (int c = 0; c < 300; c++) begin
      if (!p0_req && !p1_req && exp_q.size() == 0 && gnt_q.size() == 0 && !busy) begin
        done = 1;
        break;
      end
      @(negedge clk);
      g0 = p0_gnt; g1 = p1_gnt;
      @(posedge clk); #1;
      if (g0) begin p0_req = 0; p0_addr = $urandom; p0_wdata = $urandom; p0_be = 4'($urandom); end
      if (g1) begin p1_req = 0; p1_addr = $urandom; p1_wdata = $urandom; p1_be = 4'($urandom); end
    end
    chk("round_complete", done, 1);
  endtask

  initial begin
    txn_t a, b;
    int   mask;
    rst = 1;
    p0_req = 0; p0_addr = '0; p0_we = 0; p0_be = '0; p0_wdata = '0;
    p1_req = 0; p1_addr = '0; p1_we = 0; p1_be = '0; p1_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    @(posedge clk); #1;
    rst = 0;

    // Both primaries together, immediate subordinate: expect p0,p1,p0,p1
    for (int k = 0; k < 2; k++) begin
      a = mk_txn(32'h100 + 32'(k), 0, 4'hF, 0, 32'h1000_0000 + 32'(k), 0, 0, M_NORM);
      b = mk_txn(32'h200 + 32'(k), 1, 4'hF, 32'h55, 32'h2000_0000 + 32'(k), 0, 0, M_NORM);
      run_round(1, 1, a, b);
    end
    // Single read with delayed grant and response
    run_round(1, 0, mk_txn(32'h1000, 0, 4'hF, 0, 32'hCAFE_0001, 2, 3, M_NORM), rand_txn());
    // Write held 10 cycles without grant
    run_round(0, 1, rand_txn(), mk_txn(32'h20, 1, 4'b0011, 32'hA5A5_A5A5, 32'h0, 10, 0, M_NORM));
    // Timeout with late response, then response exactly on the expiry cycle
    run_round(1, 0, mk_txn(32'h40, 0, 4'hF, 0, 32'h0, 1, 0, M_TMO), rand_txn());
    run_round(0, 1, rand_txn(), mk_txn(32'h44, 0, 4'hF, 0, 32'h600D_0006, 0, TMO - 1, M_EXACT));
    // Timeout on the first of a contended pair
    a = rand_txn(); a.mode = M_TMO;
    run_round(1, 1, a, rand_txn());

    // Reset asserted during RESP
    @(negedge clk);
    sub_en = 0;
    @(posedge clk); #1;
    p0_req = 1; p0_addr = 32'h300; p0_we = 0; p0_be = 4'hF; p0_wdata = 0;
    gnt_q.push_back(0);
    for (int c = 0; c < 20 && !s_req; c++) begin @(posedge clk); #1; end
    chk("rst_req_seen", s_req, 1);
    s_gnt = 1;
    @(posedge clk); #1;
    s_gnt = 0; p0_req = 0;
    @(posedge clk); #1;
    s_rvalid = 1; s_rdata = 32'h1234_5678; rst = 1;
    #1;
    check_zero("rst_in_resp");
    repeat (2) @(posedge clk);
    #1;
    rst = 0; s_rvalid = 0; s_rdata = '0;
    prio = 0;
    chk("rst_gnt_consumed", gnt_q.size(), 0);
    @(negedge clk);
    sub_en = 1;
    run_round(0, 1, rand_txn(), rand_txn());
    run_round(1, 1, rand_txn(), rand_txn());

    // Randomized rounds
    for (int k = 0; k < 60; k++) begin
      mask = int'($urandom_range(1, 3));
      run_round(mask[0], mask[1], rand_txn(), rand_txn());
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    chk("leftover_expectations", exp_q.size() + gnt_q.size() + plan_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
